uart_rx_frame_parser: RTL and testbench
=======================================

UART_RX_FRAME_PARSER -- requirements
Module: uart_rx_frame_parser

Interface
REQ-001 SHALL have parameter P_UART_DATA_WIDTH, default 8, byte width; all data ports and the checksum are this width.
REQ-002 SHALL have parameter P_HEAD0, default 8'h55, first header byte.
REQ-003 SHALL have parameter P_HEAD1, default 8'hAA, second header byte.
REQ-004 SHALL have parameter P_MAX_LEN, default 16, maximum payload bytes; also the payload buffer depth.
REQ-005 SHALL have parameter P_TIMEOUT, default 1000, idle clock cycles allowed between bytes inside a frame.
REQ-006 SHALL have port i_clk  input  1  the single clock; all logic is on its rising edge.
REQ-007 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-008 SHALL have port i_rx_data  input  P_UART_DATA_WIDTH  received byte from the UART receiver.
REQ-009 SHALL have port i_rx_valid  input  1  one-cycle strobe qualifying i_rx_data; there is no backpressure.
REQ-010 SHALL have port o_frame_data  output  P_UART_DATA_WIDTH  payload byte out.
REQ-011 SHALL have port o_frame_valid  output  1  o_frame_data is valid.
REQ-012 SHALL have port o_frame_last  output  1  marks the final payload byte; qualified by o_frame_valid.
REQ-013 SHALL have port i_frame_ready  input  1  downstream accepts the byte.
REQ-014 SHALL have port o_frame_len  output  8  LEN of the frame being output; held until the next frame.
REQ-015 SHALL have port o_err  output  1  one-cycle error pulse.
REQ-016 SHALL have port o_err_code  output  2  error cause: 1 = bad LEN, 2 = bad SUM, 3 = timeout; held until the next error.
REQ-017 SHALL have port o_drop  output  1  one-cycle pulse when an input byte is discarded during S_OUT.

Function
REQ-018 SHALL accept frames in the format HEAD0, HEAD1, LEN, payload[LEN], SUM, where SUM = (LEN + sum of payload) mod 2^P_UART_DATA_WIDTH.
REQ-019 SHALL use an FSM with states S_IDLE, S_HEAD1, S_LEN, S_PAY, S_SUM and S_OUT; bytes are consumed only on cycles where i_rx_valid=1.
REQ-020 S_IDLE SHALL move to S_HEAD1 on byte==P_HEAD0 and otherwise ignore the byte silently.
REQ-021 S_HEAD1 SHALL move to S_LEN on byte==P_HEAD1, stay in S_HEAD1 on byte==P_HEAD0, and return to S_IDLE on any other byte, with no error.
REQ-022 S_LEN SHALL, when LEN==0 or LEN>P_MAX_LEN, pulse o_err with code 1 and go to S_IDLE.
REQ-023 S_LEN SHALL otherwise latch LEN, seed the checksum with LEN, clear the write index and go to S_PAY.
REQ-024 S_PAY SHALL write each byte to buffer[index], add it to the checksum and increment the index, going to S_SUM after the LEN-th byte.
REQ-025 S_SUM SHALL go to S_OUT on byte==checksum; on mismatch it SHALL pulse o_err with code 2 and go to S_IDLE, discarding the buffer.
REQ-026 SHALL register o_frame_valid=1 with buffer[0] on the cycle after the SUM byte, and SHALL update o_frame_len in that same cycle.
REQ-027 In S_OUT, each cycle with o_frame_valid&&i_frame_ready SHALL advance to the next byte, and the read index SHALL wrap to 0 after the last byte.
REQ-028 o_frame_last SHALL be 1 exactly when the presented byte is index LEN-1.
REQ-029 o_frame_data, o_frame_last and o_frame_valid SHALL stay stable while o_frame_valid=1 and i_frame_ready=0.
REQ-030 The handshake on the last byte SHALL drop o_frame_valid the next cycle, and the FSM SHALL return to S_IDLE.
REQ-031 In S_OUT, every i_rx_valid byte SHALL be discarded with an o_drop pulse.
REQ-032 A timeout counter SHALL clear on every accepted byte and count in S_HEAD1, S_LEN, S_PAY and S_SUM.
REQ-033 When the timeout counter reaches P_TIMEOUT, the block SHALL pulse o_err with code 3 and go to S_IDLE.
REQ-034 The timeout counter SHALL be held at 0 in S_IDLE and S_OUT.
REQ-035 When a timeout expires in the same cycle that a byte arrives, the byte SHALL win: it is processed and there is no timeout.
REQ-036 Checksum addition SHALL be modulo 2^P_UART_DATA_WIDTH with the carry discarded.

Reset
REQ-037 While i_rst=1, the block SHALL be asynchronously forced to S_IDLE.
REQ-038 While i_rst=1, o_frame_valid, o_frame_last, o_err and o_drop SHALL be 0.
REQ-039 While i_rst=1, o_frame_data, o_frame_len, o_err_code and all counters, indices and checksum SHALL be 0; buffer contents need not be reset.
REQ-040 Reset asserted mid-frame or mid-output SHALL abandon the frame, with no partial output after release.

Verification
REQ-041 The bench SHALL send 55 AA 03 11 22 33 69 with ready=1 -> outputs 11,22,33 on consecutive cycles, last on 33, o_frame_len=3, no err.
REQ-042 The bench SHALL send the same frame with SUM=6A -> o_err pulse with code 2 and no o_frame_valid.
REQ-043 The bench SHALL send 55 AA 00, then 55 AA 11 (P_MAX_LEN=16) -> two o_err pulses with code 1.
REQ-044 The bench SHALL send 55 55 AA 01 7F 80 -> one frame containing 7F with last=1.
REQ-045 The bench SHALL send 55 AA 02 01, then leave the line idle for P_TIMEOUT cycles -> o_err with code 3, then accept a following valid frame.
REQ-046 The bench SHALL hold ready=0 for 5 cycles during output and inject 2 bytes -> data stable, two o_drop pulses, and the frame completes intact once ready=1.

Source files
------------

// File: rtl/uart_rx_frame_parser_if.sv
// Signal bundle between a byte-wide UART receiver, the frame parser and the
// downstream payload consumer. The slave modport is the parser's view; the
// master modport is the view of whatever drives the parser (UART side and
// downstream sink together).
interface uart_rx_frame_parser_if #(
  parameter int P_UART_DATA_WIDTH = 8
);
  logic [P_UART_DATA_WIDTH-1:0] i_rx_data;
  logic                         i_rx_valid;
  logic [P_UART_DATA_WIDTH-1:0] o_frame_data;
  logic                         o_frame_valid;
  logic                         o_frame_last;
  logic                         i_frame_ready;
  logic [7:0]                   o_frame_len;
  logic                         o_err;
  logic [1:0]                   o_err_code;
  logic                         o_drop;

  modport slave (
    input  i_rx_data, i_rx_valid, i_frame_ready,
    output o_frame_data, o_frame_valid, o_frame_last,
           o_frame_len, o_err, o_err_code, o_drop
  );

  modport master (
    output i_rx_data, i_rx_valid, i_frame_ready,
    input  o_frame_data, o_frame_valid, o_frame_last,
           o_frame_len, o_err, o_err_code, o_drop
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Frame parser for a byte stream: HEAD0 HEAD1 LEN payload[LEN] SUM.
// The payload is buffered and only released downstream once SUM matches.
//
// state   | meaning
// S_IDLE  | hunting for HEAD0
// S_HEAD1 | HEAD0 seen, expecting HEAD1 (a repeated HEAD0 re-arms)
// S_LEN   | expecting LEN, range-checked against P_MAX_LEN
// S_PAY   | buffering payload bytes, accumulating checksum
// S_SUM   | expecting checksum byte
// S_OUT   | presenting buffered payload; incoming bytes are dropped
module uart_rx_frame_parser #(
  parameter int                           P_UART_DATA_WIDTH = 8,
  parameter logic [P_UART_DATA_WIDTH-1:0] P_HEAD0           = 8'h55,
  parameter logic [P_UART_DATA_WIDTH-1:0] P_HEAD1           = 8'hAA,
  parameter int                           P_MAX_LEN         = 16,
  parameter int                           P_TIMEOUT         = 1000
) (
  input logic                   i_clk,
  input logic                   i_rst,
  uart_rx_frame_parser_if.slave bus
);

  localparam int DW    = P_UART_DATA_WIDTH;
  localparam int IDX_W = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
  localparam int TMO_W = $clog2(P_TIMEOUT + 1);

  localparam logic [DW-1:0]    ONE      = DW'(1);
  localparam logic [DW-1:0]    MAX_LEN  = DW'(P_MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(P_TIMEOUT - 1);

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_SUM = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD1, S_LEN, S_PAY, S_SUM, S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    len_q, len_d;
  logic [DW-1:0]    wr_q, wr_d;
  logic [DW-1:0]    rd_q, rd_d;
  logic [DW-1:0]    sum_q, sum_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [DW-1:0]    data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [7:0]       flen_q, flen_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             drop_q, drop_d;

  logic [DW-1:0]    mem_q [P_MAX_LEN];
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [DW-1:0]    rd_nxt;
  logic             in_frame;
  logic [DW-1:0]    rx;
  logic             rx_v;

  assign rx        = bus.i_rx_data;
  assign rx_v      = bus.i_rx_valid;
  assign mem_waddr = wr_q[IDX_W-1:0];
  assign rd_nxt    = rd_q + ONE;
  assign in_frame  = (state_q == S_HEAD1) || (state_q == S_LEN) ||
                     (state_q == S_PAY)   || (state_q == S_SUM);

  // Payload buffer; contents are don't-care after reset so it has none.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[mem_waddr] <= rx;
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      flen_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      flen_q  <= flen_d;
      err_q   <= err_d;
      code_q  <= code_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic: byte parsing, inter-byte timeout and payload output.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    sum_d   = sum_q;
    tmo_d   = '0;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    flen_d  = flen_q;
    err_d   = 1'b0;
    code_d  = code_q;
    drop_d  = 1'b0;
    mem_we  = 1'b0;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (in_frame && !rx_v) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        code_d  = ERR_TMO;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rx_v && rx == P_HEAD0) state_d = S_HEAD1;
      end
      S_HEAD1: begin
        if (rx_v) begin
          if (rx == P_HEAD1)      state_d = S_LEN;
          else if (rx == P_HEAD0) state_d = S_HEAD1;
          else                    state_d = S_IDLE;
        end
      end
      S_LEN: begin
        if (rx_v) begin
          if (rx == '0 || rx > MAX_LEN) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = S_IDLE;
          end else begin
            len_d   = rx;
            sum_d   = rx;
            wr_d    = '0;
            state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (rx_v) begin
          mem_we = 1'b1;
          sum_d  = sum_q + rx;
          wr_d   = wr_q + ONE;
          if (wr_q + ONE == len_q) state_d = S_SUM;
        end
      end
      S_SUM: begin
        if (rx_v) begin
          if (rx == sum_q) begin
            state_d = S_OUT;
            valid_d = 1'b1;
            data_d  = mem_q[0];
            last_d  = (len_q == ONE);
            flen_d  = 8'(len_q);
            rd_d    = '0;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_SUM;
            state_d = S_IDLE;
          end
        end
      end
      S_OUT: begin
        drop_d = rx_v;
        if (valid_q && bus.i_frame_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            rd_d    = '0;
            state_d = S_IDLE;
          end else begin
            rd_d   = rd_nxt;
            data_d = mem_q[rd_nxt[IDX_W-1:0]];
            last_d = (rd_nxt == len_q - ONE);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_frame_data  = data_q;
  assign bus.o_frame_valid = valid_q;
  assign bus.o_frame_last  = last_q;
  assign bus.o_frame_len   = flen_q;
  assign bus.o_err         = err_q;
  assign bus.o_err_code    = code_q;
  assign bus.o_drop        = drop_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser with hand-computed frames.
module tb_uart_rx_frame_parser;
  localparam int DW   = 8;
  localparam int MAXL = 16;
  localparam int TMO  = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  uart_rx_frame_parser_if #(.P_UART_DATA_WIDTH(DW)) bus ();

  uart_rx_frame_parser #(
    .P_UART_DATA_WIDTH(DW),
    .P_HEAD0(8'h55),
    .P_HEAD1(8'hAA),
    .P_MAX_LEN(MAXL),
    .P_TIMEOUT(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Event monitors, sampled on the falling edge.
  int         err_cnt = 0;
  int         drop_cnt = 0;
  int         valid_cycles = 0;
  logic [7:0] hs_data[$];
  logic       hs_last[$];

  always @(negedge clk) begin
    if (bus.o_err)  err_cnt++;
    if (bus.o_drop) drop_cnt++;
    if (bus.o_frame_valid) begin
      valid_cycles++;
      if (bus.i_frame_ready) begin
        hs_data.push_back(bus.o_frame_data);
        hs_last.push_back(bus.o_frame_last);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one byte for exactly one cycle; entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (bus.o_frame_valid !== 1'b0 || bus.o_frame_last !== 1'b0 ||
        bus.o_err !== 1'b0 || bus.o_drop !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: valid=%b last=%b err=%b drop=%b required all 0",
               bus.o_frame_valid, bus.o_frame_last, bus.o_err, bus.o_drop);
    end
    checks++;
    if (bus.o_frame_data !== 8'h00 || bus.o_frame_len !== 8'h00 || bus.o_err_code !== 2'd0) begin
      failures++;
      $display("FAIL reset_values: data=%h len=%h code=%0d required 0",
               bus.o_frame_data, bus.o_frame_len, bus.o_err_code);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame;
    int e0 = err_cnt;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h69);
    checks++;
    if (bus.o_frame_valid !== 1'b1 || bus.o_frame_data !== 8'h11 ||
        bus.o_frame_last !== 1'b0 || bus.o_frame_len !== 8'd3) begin
      failures++;
      $display("FAIL good_byte0: valid=%b data=%h last=%b len=%0d required 1 11 0 3",
               bus.o_frame_valid, bus.o_frame_data, bus.o_frame_last, bus.o_frame_len);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_frame_valid !== 1'b1 || bus.o_frame_data !== 8'h22 || bus.o_frame_last !== 1'b0) begin
      failures++;
      $display("FAIL good_byte1: valid=%b data=%h last=%b required 1 22 0",
               bus.o_frame_valid, bus.o_frame_data, bus.o_frame_last);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_frame_valid !== 1'b1 || bus.o_frame_data !== 8'h33 || bus.o_frame_last !== 1'b1) begin
      failures++;
      $display("FAIL good_byte2: valid=%b data=%h last=%b required 1 33 1",
               bus.o_frame_valid, bus.o_frame_data, bus.o_frame_last);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_frame_valid !== 1'b0 || err_cnt !== e0) begin
      failures++;
      $display("FAIL good_end: valid=%b errs=%0d required 0 %0d",
               bus.o_frame_valid, err_cnt, e0);
    end
  endtask

  task automatic test_bad_sum;
    int e0 = err_cnt;
    int v0 = valid_cycles;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h6A);
    idle(3);
    checks++;
    if (err_cnt !== e0 + 1 || bus.o_err_code !== 2'd2) begin
      failures++;
      $display("FAIL bad_sum_err: pulses=%0d code=%0d required %0d 2",
               err_cnt - e0, bus.o_err_code, 1);
    end
    checks++;
    if (valid_cycles !== v0) begin
      failures++;
      $display("FAIL bad_sum_novalid: valid cycles=%0d required 0", valid_cycles - v0);
    end
  endtask

  task automatic test_bad_len;
    int e0 = err_cnt;
    int n;
    logic [7:0] sum;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00);
    idle(2);
    checks++;
    if (err_cnt !== e0 + 1 || bus.o_err_code !== 2'd1) begin
      failures++;
      $display("FAIL len_zero: pulses=%0d code=%0d required 1 1", err_cnt - e0, bus.o_err_code);
    end
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h11);
    idle(2);
    checks++;
    if (err_cnt !== e0 + 2 || bus.o_err_code !== 2'd1) begin
      failures++;
      $display("FAIL len_over: pulses=%0d code=%0d required 2 1", err_cnt - e0, bus.o_err_code);
    end
    // LEN equal to the maximum is accepted: payload 01..10, SUM = 0x10 + 136 = 0x98.
    hs_data.delete(); hs_last.delete();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h10);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    send_byte(8'h98);
    n = 0;
    while (hs_data.size() < 16 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (hs_data.size() !== 16 || bus.o_frame_len !== 8'd16) begin
      failures++;
      $display("FAIL len_max_count: bytes=%0d len=%0d required 16 16",
               hs_data.size(), bus.o_frame_len);
    end
    for (int i = 0; i < hs_data.size(); i++) begin
      checks++;
      if (hs_data[i] !== 8'(i + 1) || hs_last[i] !== (i == 15)) begin
        failures++;
        $display("FAIL len_max_byte%0d: data=%h last=%b required %h %b",
                 i, hs_data[i], hs_last[i], 8'(i + 1), (i == 15));
      end
    end
    sum = 8'h00;
    checks++;
    if (err_cnt !== e0 + 2) begin
      failures++;
      $display("FAIL len_max_noerr: pulses=%0d required 2", err_cnt - e0);
    end
    idle(2);
  endtask

  task automatic test_head_resync;
    int n = 0;
    hs_data.delete(); hs_last.delete();
    send_byte(8'h55); send_byte(8'h55); send_byte(8'hAA);
    send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    while (hs_data.size() < 1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    idle(2);
    checks++;
    if (hs_data.size() !== 1) begin
      failures++;
      $display("FAIL resync_count: bytes=%0d required 1", hs_data.size());
    end else begin
      checks++;
      if (hs_data[0] !== 8'h7F || hs_last[0] !== 1'b1) begin
        failures++;
        $display("FAIL resync_byte: data=%h last=%b required 7f 1", hs_data[0], hs_last[0]);
      end
    end
  endtask

  task automatic test_timeout;
    int e0 = err_cnt;
    int n = 0;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01);
    while (err_cnt == e0 && bus.o_err !== 1'b1 && n < TMO + 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (bus.o_err !== 1'b1 || n !== TMO || bus.o_err_code !== 2'd3) begin
      failures++;
      $display("FAIL timeout_fire: err=%b idle cycles=%0d code=%0d required 1 %0d 3",
               bus.o_err, n, bus.o_err_code, TMO);
    end
    idle(1);
    // Following frame with carry-wrapping checksum: 02+FF+FF = 0x200 -> 00.
    hs_data.delete(); hs_last.delete();
    e0 = err_cnt;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00);
    idle(4);
    checks++;
    if (hs_data.size() !== 2 || err_cnt !== e0) begin
      failures++;
      $display("FAIL timeout_recover: bytes=%0d errs=%0d required 2 0", hs_data.size(), err_cnt - e0);
    end else begin
      checks++;
      if (hs_data[0] !== 8'hFF || hs_data[1] !== 8'hFF || hs_last[0] !== 1'b0 || hs_last[1] !== 1'b1) begin
        failures++;
        $display("FAIL timeout_recover_data: %h/%b %h/%b required ff/0 ff/1",
                 hs_data[0], hs_last[0], hs_data[1], hs_last[1]);
      end
    end
  endtask

  task automatic test_timeout_byte_wins;
    int e0 = err_cnt;
    hs_data.delete(); hs_last.delete();
    send_byte(8'h55); send_byte(8'hAA);
    idle(TMO - 1);
    send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    idle(3);
    checks++;
    if (err_cnt !== e0 || hs_data.size() !== 1) begin
      failures++;
      $display("FAIL byte_wins: errs=%0d bytes=%0d required 0 1", err_cnt - e0, hs_data.size());
    end
  endtask

  task automatic test_backpressure;
    int d0 = drop_cnt;
    int v0;
    int n = 0;
    bus.i_frame_ready = 1'b0;
    hs_data.delete(); hs_last.delete();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h69);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.o_frame_valid !== 1'b1 || bus.o_frame_data !== 8'h11 || bus.o_frame_last !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: valid=%b data=%h last=%b required 1 11 0",
                 i, bus.o_frame_valid, bus.o_frame_data, bus.o_frame_last);
      end
      if (i == 1) send_byte(8'h55);
      else if (i == 3) send_byte(8'hAA);
      else idle(1);
    end
    bus.i_frame_ready = 1'b1;
    while (hs_data.size() < 3 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    v0 = valid_cycles;
    idle(4);
    checks++;
    if (drop_cnt !== d0 + 2) begin
      failures++;
      $display("FAIL stall_drops: pulses=%0d required 2", drop_cnt - d0);
    end
    checks++;
    if (hs_data.size() !== 3) begin
      failures++;
      $display("FAIL stall_count: bytes=%0d required 3", hs_data.size());
    end else begin
      checks++;
      if (hs_data[0] !== 8'h11 || hs_data[1] !== 8'h22 || hs_data[2] !== 8'h33 ||
          hs_last[0] !== 1'b0 || hs_last[1] !== 1'b0 || hs_last[2] !== 1'b1) begin
        failures++;
        $display("FAIL stall_data: %h %h %h last %b%b%b required 11 22 33 last 001",
                 hs_data[0], hs_data[1], hs_data[2], hs_last[0], hs_last[1], hs_last[2]);
      end
    end
    checks++;
    if (valid_cycles !== v0) begin
      failures++;
      $display("FAIL stall_noextra: extra valid cycles=%0d required 0", valid_cycles - v0);
    end
  endtask

  task automatic test_back_to_back;
    int d0 = drop_cnt;
    hs_data.delete(); hs_last.delete();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01);
    send_byte(8'h7F); send_byte(8'h80);
    idle(1);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00);
    idle(4);
    checks++;
    if (hs_data.size() !== 3 || drop_cnt !== d0 || bus.o_frame_len !== 8'd2) begin
      failures++;
      $display("FAIL b2b_count: bytes=%0d drops=%0d len=%0d required 3 0 2",
               hs_data.size(), drop_cnt - d0, bus.o_frame_len);
    end else begin
      checks++;
      if (hs_data[0] !== 8'h7F || hs_data[1] !== 8'hFF || hs_data[2] !== 8'hFF ||
          hs_last[0] !== 1'b1 || hs_last[1] !== 1'b0 || hs_last[2] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_data: %h %h %h last %b%b%b required 7f ff ff last 101",
                 hs_data[0], hs_data[1], hs_data[2], hs_last[0], hs_last[1], hs_last[2]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    int v0;
    int e0;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    v0 = valid_cycles;
    e0 = err_cnt;
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    idle(4);
    checks++;
    if (valid_cycles !== v0 || err_cnt !== e0) begin
      failures++;
      $display("FAIL rst_midframe: valid cycles=%0d errs=%0d required 0 0",
               valid_cycles - v0, err_cnt - e0);
    end
    // Reset while a frame is being presented under backpressure.
    bus.i_frame_ready = 1'b0;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01);
    send_byte(8'h7F); send_byte(8'h80);
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if (bus.o_frame_valid !== 1'b0 || bus.o_frame_data !== 8'h00 || bus.o_frame_len !== 8'h00) begin
      failures++;
      $display("FAIL rst_async: valid=%b data=%h len=%h required 0 00 00",
               bus.o_frame_valid, bus.o_frame_data, bus.o_frame_len);
    end
    @(negedge clk); rst = 1'b0;
    bus.i_frame_ready = 1'b1;
    @(posedge clk); #1;
    v0 = valid_cycles;
    idle(4);
    checks++;
    if (valid_cycles !== v0) begin
      failures++;
      $display("FAIL rst_midout: valid cycles after release=%0d required 0", valid_cycles - v0);
    end
  endtask

  initial begin
    bus.i_rx_data     = 8'h00;
    bus.i_rx_valid    = 1'b0;
    bus.i_frame_ready = 1'b1;
    test_reset;
    test_good_frame;
    test_bad_sum;
    test_bad_len;
    test_head_resync;
    test_timeout;
    test_timeout_byte_wins;
    test_backpressure;
    test_back_to_back;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
